// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with one register stage per shift-amount bit and valid/ready on both sides.
// The whole pipeline freezes while out_valid && !out_ready. Define BSH_CARRY_EN to add the registered out_carry port.
module pipelined_barrel_shifter #(
  parameter  int WIDTH   = 8,
  localparam int SHIFT_W = $clog2(WIDTH) + 1,
  localparam int LATENCY = SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef BSH_CARRY_EN
  output logic               out_carry,
`endif
  output logic [WIDTH-1:0]   out_data
);

  localparam logic [1:0]       MODE_LSL = 2'b00;
  localparam logic [1:0]       MODE_LSR = 2'b01;
  localparam logic [1:0]       MODE_ASR = 2'b10;
  localparam logic [WIDTH-1:0] ONES     = '1;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    localparam int A = 1 << k;

    logic [WIDTH-1:0]   d_in, d_nxt, d_q;
    logic [SHIFT_W-1:k] s_in;
    logic [1:0]         m_in;
    logic               sg_in, v_in, v_q;

    if (k == 0) begin : g_src
      assign d_in  = in_data;
      assign s_in  = in_shift;
      assign m_in  = in_mode;
      assign sg_in = in_data[WIDTH-1];
      assign v_in  = in_valid;
    end else begin : g_src
      assign d_in  = g_stage[k-1].d_q;
      assign s_in  = g_stage[k-1].g_ctl.s_q;
      assign m_in  = g_stage[k-1].g_ctl.m_q;
      assign sg_in = g_stage[k-1].g_ctl.sg_q;
      assign v_in  = g_stage[k-1].v_q;
    end

    // At A == WIDTH the shifts collapse naturally: LSL/LSR to 0, ASR to all-sign, ROR to identity.
    always_comb begin
      d_nxt = d_in;
      if (s_in[k]) begin
        case (m_in)
          MODE_LSL: d_nxt = d_in << A;
          MODE_LSR: d_nxt = d_in >> A;
          MODE_ASR: d_nxt = (d_in >> A) | (sg_in ? ~(ONES >> A) : '0);
          default:  d_nxt = (d_in >> A) | (d_in << (WIDTH - A));
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else if (!stall) begin
        d_q <= d_nxt;
        v_q <= v_in;
      end
    end

    if (k < LATENCY - 1) begin : g_ctl
      logic [SHIFT_W-1:k+1] s_q;
      logic [1:0]           m_q;
      logic                 sg_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q  <= '0;
          m_q  <= '0;
          sg_q <= 1'b0;
        end else if (!stall) begin
          s_q  <= s_in[SHIFT_W-1:k+1];
          m_q  <= m_in;
          sg_q <= sg_in;
        end
      end
    end

`ifdef BSH_CARRY_EN
    logic c_in, c_nxt, c_q;
    if (k == 0) begin : g_csrc
      assign c_in = 1'b0;
    end else begin : g_csrc
      assign c_in = g_stage[k-1].c_q;
    end

    // The last active stage defines the carry; once lower stages have shifted, s > WIDTH yields 0 or sign.
    always_comb begin
      c_nxt = c_in;
      if (s_in[k]) begin
        case (m_in)
          MODE_LSL:           c_nxt = d_in[WIDTH-A];
          MODE_LSR, MODE_ASR: c_nxt = d_in[A-1];
          default:            c_nxt = d_nxt[WIDTH-1];
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         c_q <= 1'b0;
      else if (!stall) c_q <= c_nxt;
    end
`endif
  end

  assign out_valid = g_stage[LATENCY-1].v_q;
  assign out_data  = g_stage[LATENCY-1].d_q;
`ifdef BSH_CARRY_EN
  assign out_carry = g_stage[LATENCY-1].c_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: WIDTH=8 instance for handshake/stall/reset, WIDTH=32 instance for data sweep.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] in_shift;
  logic [1:0] in_mode;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [5:0]  b_in_shift;
  logic [1:0]  b_in_mode;

`ifdef BSH_CARRY_EN
  logic out_carry, b_out_carry;
`endif

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef BSH_CARRY_EN
    .out_carry(out_carry),
`endif
    .out_data(out_data)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shift(b_in_shift), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef BSH_CARRY_EN
    .out_carry(b_out_carry),
`endif
    .out_data(b_out_data)
  );

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, data} for width w (<= 32).
  function automatic logic [32:0] ref_model(input logic [31:0] d, input int s, input logic [1:0] m, input int w);
    logic [63:0] mask, x, r;
    logic        sg, c;
    int          rr;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    sg   = x[w-1];
    r    = '0;
    c    = 1'b0;
    case (m)
      2'b00: begin
        r = (s >= w) ? 64'd0 : ((x << s) & mask);
        if (s >= 1 && s <= w) c = x[w-s];
      end
      2'b01: begin
        r = (s >= w) ? 64'd0 : (x >> s);
        if (s >= 1 && s <= w) c = x[s-1];
      end
      2'b10: begin
        if (s >= w) r = sg ? mask : 64'd0;
        else        r = (x >> s) | (sg ? (mask & ~(mask >> s)) : 64'd0);
        if (s >= 1 && s <= w) c = x[s-1];
        else if (s > w)       c = sg;
      end
      default: begin
        rr = s % w;
        r  = ((x >> rr) | (x << (w - rr))) & mask;
        if (s != 0) c = r[w-1];
      end
    endcase
    return {c, r[31:0]};
  endfunction

  task automatic run8(input string tag, input logic [7:0] d, input logic [3:0] s, input logic [1:0] m,
                      input logic [7:0] exp_d, input logic exp_c);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shift = s; in_mode = m; out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); in_valid = 1'b0;
    end while (!out_valid && n < 20);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_data"}, out_data, exp_d);
`ifdef BSH_CARRY_EN
    check({tag, "_carry"}, out_carry, exp_c);
`endif
  endtask

  task automatic run32(input logic [31:0] d, input int s, input logic [1:0] m);
    int n;
    logic [32:0] e;
    e = ref_model(d, s, m, 32);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_in_shift = 6'(s); b_in_mode = m;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk); b_in_valid = 1'b0;
    end while (!b_out_valid && n < 20);
    check($sformatf("w32_m%0d_s%0d_vld", m, s), b_out_valid, 1'b1);
    check($sformatf("w32_m%0d_s%0d_data", m, s), b_out_data, e[31:0]);
`ifdef BSH_CARRY_EN
    check($sformatf("w32_m%0d_s%0d_carry", m, s), b_out_carry, e[32]);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] full_exp [4];
    logic [7:0] exp_q [$];
    logic [7:0] hold, wd;
    logic [3:0] ws;
    logic [1:0] wm;
    logic [32:0] e;
    logic stalled, acc, take;
    int sent, got, cyc, seen;

    checks = 0; failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shift = '0; b_in_mode = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef BSH_CARRY_EN
    check("rst_out_carry", out_carry, 1'b0);
`endif

    // Main function, boundaries and a few extra hand-computed vectors.
    run8("lsl_s5",  8'hAA, 4'd5,  2'b00, 8'h40, 1'b1);
    run8("lsr_s5",  8'hAA, 4'd5,  2'b01, 8'h05, 1'b0);
    run8("asr_s5",  8'hAA, 4'd5,  2'b10, 8'hFD, 1'b0);
    run8("ror_s5",  8'hAA, 4'd5,  2'b11, 8'h55, 1'b0);
    run8("asr_s12", 8'hAA, 4'd12, 2'b10, 8'hFF, 1'b1);
    run8("lsl_s8",  8'hAA, 4'd8,  2'b00, 8'h00, 1'b0);
    run8("lsr_s8",  8'hAA, 4'd8,  2'b01, 8'h00, 1'b1);
    run8("ror_s8",  8'hAA, 4'd8,  2'b11, 8'hAA, 1'b1);
    run8("lsl_s0",  8'hAA, 4'd0,  2'b00, 8'hAA, 1'b0);
    run8("lsr_s0",  8'hAA, 4'd0,  2'b01, 8'hAA, 1'b0);
    run8("asr_s0",  8'hAA, 4'd0,  2'b10, 8'hAA, 1'b0);
    run8("ror_s0",  8'hAA, 4'd0,  2'b11, 8'hAA, 1'b0);
    run8("ror_s3",  8'h96, 4'd3,  2'b11, 8'hD2, 1'b1);
    run8("lsl_s1",  8'h81, 4'd1,  2'b00, 8'h02, 1'b1);
    run8("lsr_s15", 8'hFF, 4'd15, 2'b01, 8'h00, 1'b0);
    run8("asr_pos3", 8'h70, 4'd3, 2'b10, 8'h0E, 1'b0);
    run8("asr_pos8", 8'h70, 4'd8, 2'b10, 8'h00, 1'b0);

    // Stream of 16 words with out_ready pattern 1,0,0 repeating.
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; hold = '0;
    while ((sent < 16 || got < 16) && cyc < 300) begin
      @(negedge clk);
      if (stalled) check("stream_hold", out_data, hold);
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 16);
      wd = 8'(sent * 37 + 5);
      ws = 4'((sent * 7) % 13);
      wm = 2'(sent % 4);
      in_data = wd; in_shift = ws; in_mode = wm;
      #1;
      check("stream_in_ready", in_ready, !(out_valid && !out_ready));
      acc     = in_valid && in_ready;
      take    = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      hold    = out_data;
      if (take) begin
        if (exp_q.size() == 0) check("stream_extra", 1'b1, 1'b0);
        else                   check("stream_data", out_data, exp_q.pop_front());
        got++;
      end
      if (acc) begin
        e = ref_model({24'd0, wd}, int'(ws), wm, 8);
        exp_q.push_back(e[7:0]);
        sent++;
      end
      cyc++;
    end
    check("stream_count", got, 16);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Fill the pipeline with out_ready low, hold 10 cycles, then drain.
    full_exp[0] = 8'h20; full_exp[1] = 8'h62; full_exp[2] = 8'h8A; full_exp[3] = 8'hFE;
    out_ready = 1'b0;
    in_shift = 4'd1; in_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      case (i)
        0: in_data = 8'h10;
        1: in_data = 8'h31;
        2: in_data = 8'hC5;
        default: in_data = 8'h7F;
      endcase
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("full_in_ready", in_ready, 1'b0);
      check("full_hold_data", out_data, full_exp[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_data", out_data, full_exp[i]);
      @(negedge clk);
    end
    check("drain_empty", out_valid, 1'b0);

    // Asynchronous reset with words in flight.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hF0 | 8'(i); in_shift = 4'd0; in_mode = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_rst_no_stale", seen, 0);
    run8("post_rst_word", 8'h3C, 4'd2, 2'b01, 8'h0F, 1'b0);

    // WIDTH=32 sweep of shift amount 0..40 over all modes against the reference.
    for (int s = 0; s <= 40; s++) begin
      for (int m = 0; m < 4; m++) begin
        run32($urandom, s, 2'(m));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
